// File: rtl/vmem_bank_if.sv
// Handshake/data bundle between the vector load/store unit and vmem_bank.
interface vmem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 4
);
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] stride;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] din;
  logic              din_ack;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              ready;
  logic              done;

  modport master (
    output start, rw, addr, stride, len, din,
    input  din_ack, dout, dout_valid, ready, done
  );

  modport slave (
    input  start, rw, addr, stride, len, din,
    output din_ack, dout, dout_valid, ready, done
  );
endinterface

// File: rtl/vmem_bank.sv
// Vector memory bank: one start handshake launches a burst of fixed-latency element accesses.
// Define VMEM_STRIDE_EN to honour the captured stride; otherwise bursts are unit-stride.
module vmem_bank #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int LEN_W   = 4,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  vmem_bank_if.slave  bus
);
  localparam int CNT_W = $clog2(LATENCY);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              din_ack_q, din_ack_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [ADDR_W-1:0] step;

  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

`ifdef VMEM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q, stride_d;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    cur_addr_d   = cur_addr_q;
    rem_d        = rem_q;
    din_d        = din_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    din_ack_d    = 1'b0;
    done_d       = 1'b0;
    mem_we       = 1'b0;
`ifdef VMEM_STRIDE_EN
    stride_d     = stride_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rw_d       = bus.rw;
          cur_addr_d = bus.addr;
          rem_d      = bus.len;
          cnt_d      = CNT_RELOAD;
`ifdef VMEM_STRIDE_EN
          stride_d   = bus.stride;
`endif
          // An empty burst completes immediately without ever touching the array.
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACCESS;
            if (bus.rw) begin
              din_d     = bus.din;
              din_ack_d = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          if (rw_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d       = mem[cur_addr_q];
            dout_valid_d = 1'b1;
          end
          if (rem_q > LEN_W'(1)) begin
            cur_addr_d = cur_addr_q + step;
            rem_d      = rem_q - 1'b1;
            cnt_d      = CNT_RELOAD;
            if (rw_q) begin
              din_d     = bus.din;
              din_ack_d = 1'b1;
            end
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      din_ack_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      din_ack_q    <= din_ack_d;
      done_q       <= done_d;
    end
    cnt_q      <= cnt_d;
    rw_q       <= rw_d;
    cur_addr_q <= cur_addr_d;
    rem_q      <= rem_d;
    din_q      <= din_d;
`ifdef VMEM_STRIDE_EN
    stride_q   <= stride_d;
`endif
  end

  // A write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      mem[cur_addr_q] <= din_q;
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.done       = done_q;
  assign bus.din_ack    = din_ack_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
endmodule

// File: tb/tb_vmem_bank.sv
// Directed bench for vmem_bank (LATENCY=3); expectations follow the VMEM_STRIDE_EN setting.
module tb_vmem_bank;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int LEN_W  = 4;
  localparam int LAT    = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  vmem_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  vmem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_W-1:0] wdata [8];
  logic [DATA_W-1:0] rdata [8];
  int rcycle [8];
  int ackc [8];
  int nvalid, nack, ndone, done_cyc;
  logic ready_at_done;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launches one burst and observes it until a few cycles past done; cycle 0 is the cycle after acceptance.
  task automatic run_burst(input logic wr, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                           input logic [LEN_W-1:0] n, input int poke);
    int cyc, widx, post;
    logic seen;
    for (int i = 0; i < 8; i++) begin rdata[i] = 'x; rcycle[i] = -1; ackc[i] = -1; end
    nvalid = 0; nack = 0; ndone = 0; done_cyc = -1; ready_at_done = 1'b0;
    widx = 0; post = 0; seen = 1'b0;
    bus.start = 1'b1; bus.rw = wr; bus.addr = a; bus.stride = s; bus.len = n; bus.din = wdata[0];
    tick();
    bus.start = 1'b0;
    cyc = 0;
    for (int k = 0; k < 80; k++) begin
      if (bus.din_ack) begin
        if (nack < 8) ackc[nack] = cyc;
        nack++;
        if (widx < 7) widx++;
        bus.din = wdata[widx];
      end
      if (bus.dout_valid) begin
        if (nvalid < 8) begin rdata[nvalid] = bus.dout; rcycle[nvalid] = cyc; end
        nvalid++;
      end
      if (bus.done) begin
        ndone++;
        if (!seen) begin done_cyc = cyc; ready_at_done = bus.ready; end
        seen = 1'b1;
      end
      if (seen) post++;
      if (post >= 3) break;
      if (cyc == poke) begin
        bus.start = 1'b1; bus.rw = 1'b1; bus.addr = '0; bus.len = LEN_W'(1);
      end else begin
        bus.start = 1'b0;
      end
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    if (!seen) check("burst_timeout", 0, 1);
  endtask

  task automatic read1(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    run_burst(1'b0, a, ADDR_W'(1), LEN_W'(1), -1);
    check(tag, rdata[0], exp);
  endtask

  initial begin
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.stride = '0; bus.len = '0; bus.din = '0;
    for (int i = 0; i < 8; i++) wdata[i] = '0;

    // Reset state
    tick(); tick();
    check("rst_ready", bus.ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_din_ack", bus.din_ack, 0);
    check("rst_dout_valid", bus.dout_valid, 0);
    check("rst_dout", bus.dout, 0);
    reset_n = 1'b1;
    tick();

    // Unit-stride write 0xA,0xB,0xC to 4..6
    wdata[0] = 32'hA; wdata[1] = 32'hB; wdata[2] = 32'hC; wdata[3] = 32'h0;
    run_burst(1'b1, 6'd4, 6'd1, 4'd3, -1);
    check("wr_nack", nack, 3);
    check("wr_ack0_cyc", ackc[0], 0);
    check("wr_ack2_cyc", ackc[2], 6);
    check("wr_done_cyc", done_cyc, 9);
    check("wr_ready_at_done", ready_at_done, 1);
    check("wr_ndone", ndone, 1);
    check("wr_nvalid", nvalid, 0);

    // Read back, with a start poked mid-burst that must be ignored
    run_burst(1'b0, 6'd4, 6'd1, 4'd3, 4);
    check("rd_nvalid", nvalid, 3);
    check("rd_d0", rdata[0], 32'hA);
    check("rd_d1", rdata[1], 32'hB);
    check("rd_d2", rdata[2], 32'hC);
    check("rd_c0", rcycle[0], 3);
    check("rd_c1", rcycle[1], 6);
    check("rd_c2", rcycle[2], 9);
    check("rd_ndone", ndone, 1);
    check("rd_done_cyc", done_cyc, 9);
    read1("busy_start_no_write", 6'd0, 32'h0);

    // Strided burst wrapping past the top of the array
    wdata[0] = 32'd1; wdata[1] = 32'd2; wdata[2] = 32'd3;
    run_burst(1'b1, 6'd60, 6'd3, 4'd3, -1);
    check("str_done_cyc", done_cyc, 9);
    read1("str_m60", 6'd60, 32'd1);
`ifdef VMEM_STRIDE_EN
    read1("str_m63", 6'd63, 32'd2);
    read1("str_m2", 6'd2, 32'd3);
    read1("str_m61", 6'd61, 32'd0);
`else
    read1("str_m61", 6'd61, 32'd2);
    read1("str_m62", 6'd62, 32'd3);
    read1("str_m2", 6'd2, 32'd0);
`endif

    // len=0 write
    wdata[0] = 32'hDEAD;
    run_burst(1'b1, 6'd5, 6'd1, 4'd0, -1);
    check("len0_done_cyc", done_cyc, 0);
    check("len0_ready", ready_at_done, 1);
    check("len0_nack", nack, 0);
    check("len0_nvalid", nvalid, 0);
    read1("len0_mem5", 6'd5, 32'hB);

    // Reset at E4 of a write burst to 8..10
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 6'd8; bus.stride = 6'd1; bus.len = 4'd3; bus.din = 32'h11;
    tick();
    bus.start = 1'b0;
    check("abort_ack0", bus.din_ack, 1);
    bus.din = 32'h22;
    tick(); tick(); tick();
    check("abort_ack1", bus.din_ack, 1);
    bus.din = 32'h33;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("abort_ready", bus.ready, 1);
    check("abort_din_ack", bus.din_ack, 0);
    wdata[0] = 32'h0;
    run_burst(1'b0, 6'd8, 6'd1, 4'd3, -1);
    check("abort_m8", rdata[0], 32'h11);
    check("abort_m9", rdata[1], 32'h0);
    check("abort_m10", rdata[2], 32'h0);

    // Reset coinciding with the write edge drops the write
    bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 6'd12; bus.stride = 6'd1; bus.len = 4'd1; bus.din = 32'h55;
    tick();
    bus.start = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("coinc_done", bus.done, 0);
    check("coinc_ready", bus.ready, 1);
    read1("coinc_m12", 6'd12, 32'h0);

    // Back-to-back: start held through the done cycle
    bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 6'd4; bus.stride = 6'd1; bus.len = 4'd1;
    tick();
    check("b2b_busy", bus.ready, 0);
    tick(); tick(); tick();
    check("b2b_done1", bus.done, 1);
    check("b2b_valid1", bus.dout_valid, 1);
    check("b2b_dout1", bus.dout, 32'hA);
    check("b2b_ready1", bus.ready, 1);
    bus.addr = 6'd5;
    tick();
    bus.start = 1'b0;
    check("b2b_accept2", bus.ready, 0);
    check("b2b_valid_gap", bus.dout_valid, 0);
    tick(); tick();
    check("b2b_valid_early", bus.dout_valid, 0);
    tick();
    check("b2b_valid2", bus.dout_valid, 1);
    check("b2b_dout2", bus.dout, 32'hB);
    check("b2b_done2", bus.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
